// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: FSM state encoding and BCD score geometry.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2,
    ST_OVER = 2'd3
  } game_state_e;

  localparam int DIGITS_DEF  = 5;
  localparam int BCD_W       = 4;
  localparam int HOLDOFF_DEF = 30;

endpackage

// File: rtl/bcd_serial_cmp.sv
// Serial BCD magnitude compare, most significant digit first, one digit per clock.
// Only instantiated when HISCORE_EN is defined.
module bcd_serial_cmp
  import game_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic                  gt
);

  localparam int W  = BCD_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [IW-1:0]    idx;
  logic             running;
  logic             decided;
  logic [BCD_W-1:0] dig_a;
  logic [BCD_W-1:0] dig_b;

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx == IW'(d)) begin
        dig_a = a_q[d*BCD_W +: BCD_W];
        dig_b = b_q[d*BCD_W +: BCD_W];
      end
    end
  end

  // First unequal digit decides; reaching digit 0 with all equal means "not greater".
  assign busy = running & ~decided;
  assign done = busy & ((dig_a != dig_b) | (idx == '0));
  assign gt   = done & (dig_a > dig_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      running <= 1'b0;
      decided <= 1'b0;
    end else if (start) begin
      a_q     <= a;
      b_q     <= b;
      idx     <= IW'(DIGITS - 1);
      running <= 1'b1;
      decided <= 1'b0;
    end else if (done) begin
      decided <= 1'b1;
    end else if (busy) begin
      idx <= idx - IW'(1);
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE/RUN/DEAD/OVER flow, restart holdoff, score-counter control.
// Session high-score tracking is built only when HISCORE_EN is defined.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int DIGITS        = DIGITS_DEF,
  parameter int HOLDOFF_TICKS = HOLDOFF_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    game_tick,
  input  logic                    jump,
  input  logic                    collision,
  input  logic [BCD_W*DIGITS-1:0] score,
  output logic                    game_start,
  output logic                    game_frozen,
  output logic [1:0]              state,
  output logic [BCD_W*DIGITS-1:0] hi_score,
  output logic                    new_hi
);

  localparam int         SW       = BCD_W * DIGITS;
  localparam logic [7:0] HOLD_CNT = 8'(HOLDOFF_TICKS);

  game_state_e cur_st;
  game_state_e nxt_st;
  logic        jump_q;
  logic        press;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        start_nxt;

  assign press = jump & ~jump_q;
  assign state = cur_st;

  always_comb begin
    nxt_st    = cur_st;
    cnt_nxt   = cnt;
    start_nxt = 1'b0;
    unique case (cur_st)
      ST_IDLE: begin
        if (press) begin
          nxt_st    = ST_RUN;
          start_nxt = 1'b1;
        end
      end
      // Collision takes priority; presses are ignored while running.
      ST_RUN: begin
        if (collision) nxt_st = ST_DEAD;
      end
      ST_DEAD: begin
        if (cnt == HOLD_CNT) begin
          nxt_st  = ST_OVER;
          cnt_nxt = '0;
        end else if (game_tick) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_OVER: begin
        if (press) begin
          nxt_st    = ST_RUN;
          start_nxt = 1'b1;
          cnt_nxt   = '0;
        end
      end
      default: nxt_st = ST_IDLE;
    endcase
  end

  // Frozen is derived from the next state so it falls in the same cycle RUN is entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_st      <= ST_IDLE;
      jump_q      <= 1'b0;
      cnt         <= '0;
      game_start  <= 1'b0;
      game_frozen <= 1'b1;
    end else begin
      cur_st      <= nxt_st;
      jump_q      <= jump;
      cnt         <= cnt_nxt;
      game_start  <= start_nxt;
      game_frozen <= (nxt_st != ST_RUN);
    end
  end

`ifdef HISCORE_EN
  logic          dead_entry;
  logic [SW-1:0] snap;
  logic [SW-1:0] hi_q;
  logic          new_hi_q;
  logic          unused_cmp_busy;
  logic          cmp_done;
  logic          cmp_gt;

  // Compare starts one cycle into DEAD so the final tick's increment is in the snapshot.
  bcd_serial_cmp #(
    .DIGITS(DIGITS)
  ) u_cmp (
    .clk  (clk),
    .rst_n(rst_n),
    .start(dead_entry),
    .a    (score),
    .b    (hi_q),
    .busy (unused_cmp_busy),
    .done (cmp_done),
    .gt   (cmp_gt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dead_entry <= 1'b0;
      snap       <= '0;
      hi_q       <= '0;
      new_hi_q   <= 1'b0;
    end else begin
      dead_entry <= (cur_st == ST_RUN) && (nxt_st == ST_DEAD);
      if (dead_entry) snap <= score;
      if (cmp_done && cmp_gt) hi_q <= snap;
      if (start_nxt) new_hi_q <= 1'b0;
      else if (cmp_done) new_hi_q <= cmp_gt;
    end
  end

  assign hi_score = hi_q;
  assign new_hi   = new_hi_q;
`else
  logic unused_score;
  assign unused_score = ^score;
  assign hi_score     = '0;
  assign new_hi       = 1'b0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a BCD score-counter model; high-score checks adapt to HISCORE_EN.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int DIGITS = 5;
  localparam int W      = 4 * DIGITS;
  localparam int HOLD   = 30;
`ifdef HISCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         game_tick = 1'b0;
  logic         jump      = 1'b0;
  logic         collision = 1'b0;
  logic [W-1:0] score     = '0;
  logic         game_start;
  logic         game_frozen;
  logic [1:0]   state;
  logic [W-1:0] hi_score;
  logic         new_hi;

  logic         ld_en  = 1'b0;
  logic [W-1:0] ld_val = '0;

  logic [2:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  game_flow_ctrl #(
    .DIGITS       (DIGITS),
    .HOLDOFF_TICKS(HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_tick  (game_tick),
    .jump       (jump),
    .collision  (collision),
    .score      (score),
    .game_start (game_start),
    .game_frozen(game_frozen),
    .state      (state),
    .hi_score   (hi_score),
    .new_hi     (new_hi)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) r[d*4 +: 4] = 4'd0;
        else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // external score counter: clears on game_start, counts ticks while not frozen
  always @(posedge clk) begin
    if (ld_en) score <= ld_val;
    else if (game_start) score <= '0;
    else if (game_tick && !game_frozen) score <= bcd_inc(score);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; every game_start pulse is matched against the scoreboard
  task automatic cyc();
    logic [2:0] e;
    @(posedge clk);
    #1;
    if (game_start === 1'b1) begin
      if (exp_q.size() == 0) chk("start_unexpected", 32'(game_start), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("start_state", 32'({state, game_frozen}), 32'(e));
      end
    end
  endtask

  task automatic press(input bit starts);
    if (starts) exp_q.push_back({ST_RUN, 1'b0});
    jump = 1'b1;
    cyc();
    jump = 1'b0;
    cyc();
  endtask

  task automatic tick(input bit with_press);
    game_tick = 1'b1;
    jump      = with_press;
    cyc();
    game_tick = 1'b0;
    jump      = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic load(input logic [W-1:0] v);
    ld_val = v;
    ld_en  = 1'b1;
    cyc();
    ld_en  = 1'b0;
  endtask

  task automatic die();
    collision = 1'b1;
    cyc();
    collision = 1'b0;
  endtask

  task automatic holdoff();
    for (int i = 0; i < HOLD; i++) tick(1'b0);
    chk("holdoff_over", 32'(state), 32'(ST_OVER));
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    settle(2);
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_start", 32'(game_start), 32'd0);
    chk("rst_frozen", 32'(game_frozen), 32'd1);
    chk("rst_hi", 32'(hi_score), 32'd0);
    chk("rst_new_hi", 32'(new_hi), 32'd0);
    rst_n = 1'b1;
    cyc();

    // first press: start pulse, RUN, unfrozen in the same cycle
    exp_q.push_back({ST_RUN, 1'b0});
    jump = 1'b1;
    cyc();
    chk("t1_start", 32'(game_start), 32'd1);
    chk("t1_frozen", 32'(game_frozen), 32'd0);
    cyc();
    chk("t1_start_once", 32'(game_start), 32'd0);
    chk("t1_run", 32'(state), 32'(ST_RUN));
    jump = 1'b0;
    cyc();

    // RUN: ticks count, press ignored, tick in death cycle still counts
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("t2_score3", 32'(score), 32'h3);
    press(1'b0);
    chk("t2_press_ignored", 32'(state), 32'(ST_RUN));
    game_tick = 1'b1;
    collision = 1'b1;
    cyc();
    game_tick = 1'b0;
    collision = 1'b0;
    chk("t2_dead", 32'(state), 32'(ST_DEAD));
    chk("t2_frozen", 32'(game_frozen), 32'd1);
    chk("t2_last_tick", 32'(score), 32'h4);

    // DEAD holdoff with presses every 5 ticks
    for (int i = 1; i < HOLD; i++) tick(i % 5 == 0);
    chk("t3_dead_29", 32'(state), 32'(ST_DEAD));
    tick(1'b0);
    chk("t3_over_30", 32'(state), 32'(ST_OVER));
    chk("t3_frozen_score", 32'(score), 32'h4);
    press(1'b1);
    chk("t3_restart", 32'(state), 32'(ST_RUN));
    chk("t3_score_clr", 32'(score), 32'h0);

    // high score: beat, lower, equal
    load(20'h00123);
    die();
    settle(7);
    chk("t4_hi_123", 32'(hi_score), HS ? 32'h00123 : 32'h0);
    chk("t4_new_hi", 32'(new_hi), HS ? 32'd1 : 32'd0);
    holdoff();
    press(1'b1);
    chk("t4_new_hi_clr", 32'(new_hi), 32'd0);
    load(20'h00120);
    die();
    settle(7);
    chk("t4_hi_lower", 32'(hi_score), HS ? 32'h00123 : 32'h0);
    chk("t4_new_hi_lower", 32'(new_hi), 32'd0);
    holdoff();
    press(1'b1);
    load(20'h00123);
    die();
    settle(7);
    chk("t4_hi_equal", 32'(hi_score), HS ? 32'h00123 : 32'h0);
    chk("t4_new_hi_equal", 32'(new_hi), 32'd0);
    holdoff();
    press(1'b1);

    // MSD decides within 5 clocks of DEAD entry
    load(20'h09000);
    die();
    settle(7);
    chk("t5_hi_9000", 32'(hi_score), HS ? 32'h09000 : 32'h0);
    holdoff();
    press(1'b1);
    load(20'h10000);
    die();
    settle(5);
    chk("t5_hi_msd", 32'(hi_score), HS ? 32'h10000 : 32'h0);
    chk("t5_new_hi", 32'(new_hi), HS ? 32'd1 : 32'd0);
    holdoff();

    // collision still high on re-entry: straight back to DEAD
    collision = 1'b1;
    press(1'b1);
    collision = 1'b0;
    chk("reentry_dead", 32'(state), 32'(ST_DEAD));

    // reset mid-DEAD, then a clean run needs the full holdoff
    for (int i = 0; i < 12; i++) tick(1'b0);
    rst_n = 1'b0;
    cyc();
    chk("t6_state", 32'(state), 32'(ST_IDLE));
    chk("t6_frozen", 32'(game_frozen), 32'd1);
    chk("t6_hi", 32'(hi_score), 32'd0);
    chk("t6_new_hi", 32'(new_hi), 32'd0);
    rst_n = 1'b1;
    cyc();
    press(1'b1);
    chk("t6_run", 32'(state), 32'(ST_RUN));
    die();
    for (int i = 1; i < HOLD; i++) tick(1'b0);
    chk("t6_dead_29", 32'(state), 32'(ST_DEAD));
    tick(1'b0);
    chk("t6_over_30", 32'(state), 32'(ST_OVER));

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
